// File: rtl/dcache_pkg.sv
// Shared types and address-split width helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StRefill,
    StResp,
    StWrite
  } state_e;

  function automatic int unsigned off_w(input int unsigned wpl);
    return int'($clog2(wpl));
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return int'($clog2(lines));
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines,
                                        input int unsigned wpl);
    return addr_w - idx_w(lines) - off_w(wpl);
  endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// CPU-side and memory-side handshake bundle of the data cache.
interface dcache_dm_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic              resp_valid_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic              flush_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  // The cache itself.
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, flush_i,
    input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o,
    output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // The CPU pipeline and memory system around the cache.
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, flush_i,
    output mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o,
    input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dcache_line_ram.sv
// Cache data array: LINES x WPL words, asynchronous read, synchronous single-word write.
module dcache_line_ram
  import dcache_pkg::*;
#(
  parameter  int unsigned XLEN  = 64,
  parameter  int unsigned LINES = 8,
  parameter  int unsigned WPL   = 4,
  localparam int unsigned IdxW  = idx_w(LINES),
  localparam int unsigned OffW  = off_w(WPL)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] widx_i,
  input  logic [OffW-1:0] woff_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [IdxW-1:0] ridx_i,
  input  logic [OffW-1:0] roff_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [LINES*WPL];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{widx_i, woff_i}] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[{ridx_i, roff_i}];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with burst refill and flush.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINES  = 8,
  parameter int unsigned WPL    = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  dcache_dm_if.slave bus
);

  localparam int unsigned OffW = off_w(WPL);
  localparam int unsigned IdxW = idx_w(LINES);
  localparam int unsigned TagW = tag_w(ADDR_W, LINES, WPL);
  localparam logic [OffW-1:0] LastBeat = OffW'(WPL - 1);

  state_e            state_q, state_d;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [XLEN-1:0]   req_wdata_q;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TagW-1:0]   tag_q [LINES];
  logic [OffW-1:0]   beat_q, beat_d;
  logic              issued_q, issued_d;

  logic              accept, tag_set, hit;
  logic [OffW-1:0]   req_off;
  logic [IdxW-1:0]   req_idx;
  logic [TagW-1:0]   req_tag;

  logic              ram_we;
  logic [OffW-1:0]   ram_woff;
  logic [XLEN-1:0]   ram_wdata, ram_rdata;

  logic              req_ready, resp_valid, mem_valid, mem_we;
  logic [XLEN-1:0]   resp_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  assign req_off = req_addr_q[OffW-1:0];
  assign req_idx = req_addr_q[OffW +: IdxW];
  assign req_tag = req_addr_q[ADDR_W-1 -: TagW];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  dcache_line_ram #(
    .XLEN  (XLEN),
    .LINES (LINES),
    .WPL   (WPL)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .widx_i  (req_idx),
    .woff_i  (ram_woff),
    .wdata_i (ram_wdata),
    .ridx_i  (req_idx),
    .roff_i  (req_off),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    beat_d     = beat_q;
    issued_d   = issued_q;
    accept     = 1'b0;
    tag_set    = 1'b0;
    ram_we     = 1'b0;
    ram_woff   = req_off;
    ram_wdata  = req_wdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = !bus.flush_i && !rst_i;
        if (bus.flush_i) begin
          valid_d = '0;
        end else if (bus.req_valid_i && req_ready) begin
          accept  = 1'b1;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (req_we_q) begin
          // Write-through: keep a resident copy coherent, memory is updated in StWrite.
          ram_we  = hit;
          state_d = StWrite;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = ram_rdata;
          state_d    = StIdle;
        end else begin
          valid_d[req_idx] = 1'b0;
          beat_d           = '0;
          issued_d         = 1'b0;
          state_d          = StRefill;
        end
      end
      StRefill: begin
        // One read outstanding: the next beat is requested only after the previous returns.
        mem_valid = !issued_q;
        mem_addr  = {req_tag, req_idx, beat_q};
        if (mem_valid && bus.mem_req_ready_i) begin
          issued_d = 1'b1;
        end
        if (bus.mem_rvalid_i) begin
          issued_d  = 1'b0;
          ram_we    = 1'b1;
          ram_woff  = beat_q;
          ram_wdata = bus.mem_rdata_i;
          beat_d    = beat_q + OffW'(1);
          if (beat_q == LastBeat) begin
            tag_set          = 1'b1;
            valid_d[req_idx] = 1'b1;
            state_d          = StResp;
          end
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_rdata = ram_rdata;
        state_d    = StIdle;
      end
      StWrite: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_addr_q;
        mem_wdata = req_wdata_q;
        if (bus.mem_req_ready_i) begin
          resp_valid = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      beat_q      <= '0;
      issued_q    <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      beat_q   <= beat_d;
      issued_q <= issued_d;
      if (accept) begin
        req_we_q    <= bus.req_we_i;
        req_addr_q  <= bus.req_addr_i;
        req_wdata_q <= bus.req_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_set) begin
      tag_q[req_idx] <= req_tag;
    end
  end

  assign bus.req_ready_o     = req_ready;
  assign bus.resp_valid_o    = resp_valid;
  assign bus.resp_rdata_o    = resp_rdata;
  assign bus.mem_req_valid_o = mem_valid;
  assign bus.mem_we_o        = mem_we;
  assign bus.mem_addr_o      = mem_addr;
  assign bus.mem_wdata_o     = mem_wdata;

endmodule

// File: tb/tb_dcache_dm.sv
// Randomised self-checking bench for dcache_dm against a line-level cache model and memory.
module tb_dcache_dm;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINES  = 8;
  localparam int unsigned WPL    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_dm_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  dcache_dm #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .LINES  (LINES),
    .WPL    (WPL)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: sparse backing store plus transaction logs.
  logic [63:0] mem [int unsigned];
  int unsigned rd_log [$];
  int unsigned wr_addr [$];
  logic [63:0] wr_data [$];
  int          ready_delay = 0;
  int          rlat = 1;
  int unsigned last_rv_cyc = 0;

  function automatic logic [63:0] mem_rd(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 64'hA0 + 64'(a) - 64'h10;
  endfunction

  // Reference cache: which line (tag) each index holds.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];

  // Expected number of memory reads for a load at a; updates the model.
  function automatic int ref_load(input int unsigned a);
    int unsigned idx = (a / WPL) % LINES;
    int unsigned tag = a / (WPL * LINES);
    if (m_valid[idx] && m_tag[idx] == tag) return 0;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tag;
    return WPL;
  endfunction

  function automatic void ref_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  // Number of logged reads that are not the line of a, in order.
  function automatic int bad_burst(input int unsigned a);
    int bad = 0;
    foreach (rd_log[i]) if (rd_log[i] != (a - a % WPL) + i) bad++;
    return bad;
  endfunction

  initial begin : mem_side
    int          pend = 0;
    int          waited = 0;
    int unsigned pend_addr = 0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rvalid_i    = 1'b0;
    bus.mem_rdata_i     = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rvalid_i    = 1'b0;
      if (rst) begin
        pend   = 0;
        waited = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = mem_rd(pend_addr);
          last_rv_cyc      = cyc;
        end
      end else if (bus.mem_req_valid_o) begin
        if (waited < ready_delay) begin
          waited++;
        end else begin
          waited = 0;
          bus.mem_req_ready_i = 1'b1;
          if (bus.mem_we_o) begin
            mem[bus.mem_addr_o] = bus.mem_wdata_o;
            wr_addr.push_back(bus.mem_addr_o);
            wr_data.push_back(bus.mem_wdata_o);
          end else begin
            rd_log.push_back(bus.mem_addr_o);
            pend      = rlat;
            pend_addr = bus.mem_addr_o;
          end
        end
      end
    end
  end

  // One CPU transaction; rd is X if the cache never accepts or never responds.
  task automatic cpu_op(input bit we, input int unsigned a, input logic [63:0] wd,
                        output logic [63:0] rd, output int lat, output int unsigned resp_cyc);
    int n;
    rd_log.delete();
    wr_addr.delete();
    wr_data.delete();
    rd       = 'x;
    lat      = -1;
    resp_cyc = 0;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = a;
    bus.req_wdata_i = wd;
    #1;
    n = 0;
    while (!bus.req_ready_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready_o) begin
      bus.req_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    n = 1;
    while (!bus.resp_valid_o && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.resp_valid_o) begin
      rd       = bus.resp_rdata_o;
      lat      = n;
      resp_cyc = cyc;
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    ref_clear();
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.flush_i     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 1'b0) $display("FAIL reset_ready_during: got %b want 0", bus.req_ready_o);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", bus.req_ready_o);
    else n_pass++;
    n_checks++;
    if ({bus.resp_valid_o, bus.resp_rdata_o} !== '0)
      $display("FAIL reset_resp: got %b/%h want 0/0", bus.resp_valid_o, bus.resp_rdata_o);
    else n_pass++;
    n_checks++;
    if ({bus.mem_req_valid_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0)
      $display("FAIL reset_mem: got v=%b we=%b a=%h d=%h want all 0", bus.mem_req_valid_o,
               bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
    else n_pass++;
    ref_clear();
  endtask

  task automatic test_refill_hit();
    logic [63:0] rd;
    int lat, er;
    int unsigned rc;
    er = ref_load('h10);
    cpu_op(1'b0, 'h10, '0, rd, lat, rc);
    n_checks++;
    if (rd !== 64'hA0) $display("FAIL refill_data: got %h want %h", rd, 64'hA0);
    else n_pass++;
    n_checks++;
    if (rd_log.size() != er || bad_burst('h10) != 0)
      $display("FAIL refill_reads: got %0d reads (%0d out of order) want %0d", rd_log.size(),
               bad_burst('h10), er);
    else n_pass++;
    n_checks++;
    if (rc - last_rv_cyc != 1) $display("FAIL miss_latency: got %0d want 1", rc - last_rv_cyc);
    else n_pass++;
    er = ref_load('h12);
    cpu_op(1'b0, 'h12, '0, rd, lat, rc);
    n_checks++;
    if (rd !== 64'hA2) $display("FAIL hit_data: got %h want %h", rd, 64'hA2);
    else n_pass++;
    n_checks++;
    if (lat != 1) $display("FAIL hit_latency: got %0d want 1", lat);
    else n_pass++;
    n_checks++;
    if (rd_log.size() != er) $display("FAIL hit_reads: got %0d want %0d", rd_log.size(), er);
    else n_pass++;
  endtask

  task automatic test_store_hit();
    logic [63:0] rd;
    int lat, er;
    int unsigned rc;
    cpu_op(1'b1, 'h11, 64'h55, rd, lat, rc);
    n_checks++;
    if (rd !== '0) $display("FAIL store_hit_ack: got %h want 0", rd);
    else n_pass++;
    n_checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 'h11 || wr_data[0] !== 64'h55 || rd_log.size() != 0)
      $display("FAIL store_hit_mem: got %0d writes, %0d reads want 1 write of 55 at 11",
               wr_addr.size(), rd_log.size());
    else n_pass++;
    er = ref_load('h11);
    cpu_op(1'b0, 'h11, '0, rd, lat, rc);
    n_checks++;
    if (rd !== 64'h55 || rd_log.size() != er)
      $display("FAIL store_hit_reload: got %h/%0d reads want %h/%0d", rd, rd_log.size(),
               64'h55, er);
    else n_pass++;
  endtask

  task automatic test_store_miss();
    logic [63:0] rd;
    int lat, er;
    int unsigned rc;
    cpu_op(1'b1, 'h40, 64'h77, rd, lat, rc);
    n_checks++;
    if (rd !== '0 || wr_addr.size() != 1 || wr_addr[0] != 'h40 || wr_data[0] !== 64'h77 ||
        rd_log.size() != 0)
      $display("FAIL store_miss: got ack %h, %0d writes, %0d reads want 0, 1, 0", rd,
               wr_addr.size(), rd_log.size());
    else n_pass++;
    er = ref_load('h40);
    cpu_op(1'b0, 'h40, '0, rd, lat, rc);
    n_checks++;
    if (rd !== 64'h77 || rd_log.size() != er || bad_burst('h40) != 0)
      $display("FAIL no_allocate: got %h/%0d reads want %h/%0d", rd, rd_log.size(), 64'h77, er);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [63:0] rd;
    int lat, er, unstable, pulses;
    int unsigned rc;
    bit done;
    ready_delay = 5;
    rlat        = 4;
    er          = ref_load('h84);
    done        = 1'b0;
    unstable    = 0;
    pulses      = 0;
    fork
      begin
        cpu_op(1'b0, 'h84, '0, rd, lat, rc);
        done = 1'b1;
      end
      begin
        bit          pv = 1'b0;
        bit          pr = 1'b0;
        int unsigned pa = 0;
        for (int i = 0; i < 400 && !done; i++) begin
          @(negedge clk);
          #2;
          if (pv && !pr && (!bus.mem_req_valid_o || bus.mem_addr_o != pa)) unstable++;
          if (bus.resp_valid_o) pulses++;
          pv = bus.mem_req_valid_o;
          pr = bus.mem_req_ready_i;
          pa = bus.mem_addr_o;
        end
      end
    join
    @(negedge clk);
    #1;
    if (bus.resp_valid_o) pulses++;
    n_checks++;
    if (rd !== mem_rd('h84) || rd_log.size() != er || bad_burst('h84) != 0)
      $display("FAIL stall_data: got %h/%0d reads want %h/%0d", rd, rd_log.size(), mem_rd('h84), er);
    else n_pass++;
    n_checks++;
    if (unstable != 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable);
    else n_pass++;
    n_checks++;
    if (pulses != 1) $display("FAIL stall_pulses: got %0d want 1", pulses);
    else n_pass++;
    cpu_op(1'b1, 'h90, 64'h1234, rd, lat, rc);
    n_checks++;
    if (rd !== '0 || wr_addr.size() != 1 || wr_addr[0] != 'h90 || wr_data[0] !== 64'h1234)
      $display("FAIL stall_store: got ack %h, %0d writes want 0, 1", rd, wr_addr.size());
    else n_pass++;
    ready_delay = 0;
    rlat        = 1;
  endtask

  task automatic test_flush();
    logic [63:0] rd;
    int lat, er;
    int unsigned rc;
    er = ref_load('h10);
    cpu_op(1'b0, 'h10, '0, rd, lat, rc);
    @(negedge clk);
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 'h10;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 1'b0) $display("FAIL flush_ready: got %b want 0", bus.req_ready_o);
    else n_pass++;
    @(negedge clk);
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0)
      $display("FAIL flush_not_accepted: got ready=%b resp=%b mreq=%b want 1/0/0",
               bus.req_ready_o, bus.resp_valid_o, bus.mem_req_valid_o);
    else n_pass++;
    ref_clear();
    er = ref_load('h10);
    cpu_op(1'b0, 'h10, '0, rd, lat, rc);
    n_checks++;
    if (rd !== mem_rd('h10) || rd_log.size() != er || er != WPL)
      $display("FAIL flush_reload: got %h/%0d reads want %h/%0d", rd, rd_log.size(),
               mem_rd('h10), WPL);
    else n_pass++;
  endtask

  task automatic test_conflict();
    logic [63:0] rd;
    int lat, er;
    int unsigned rc;
    int unsigned seq [3] = '{'h10, 'h30, 'h10};
    pulse_flush();
    foreach (seq[k]) begin
      er = ref_load(seq[k]);
      cpu_op(1'b0, seq[k], '0, rd, lat, rc);
      n_checks++;
      if (rd !== mem_rd(seq[k]) || rd_log.size() != er || er != WPL || bad_burst(seq[k]) != 0)
        $display("FAIL conflict_%0d: got %h/%0d reads want %h/%0d", k, rd, rd_log.size(),
                 mem_rd(seq[k]), WPL);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [63:0] rd;
    int lat, er, n;
    int unsigned rc;
    rd_log.delete();
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 'h20;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    n = 0;
    while (rd_log.size() < 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (rd_log.size() < 3) $display("FAIL midrefill_wait: got %0d reads want 3", rd_log.size());
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.resp_rdata_o, bus.mem_req_valid_o, bus.mem_we_o,
         bus.mem_addr_o, bus.mem_wdata_o} !== '0)
      $display("FAIL midrefill_outputs: got ready=%b resp=%b mreq=%b addr=%h want all 0",
               bus.req_ready_o, bus.resp_valid_o, bus.mem_req_valid_o, bus.mem_addr_o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 1'b1) $display("FAIL midrefill_idle: got %b want 1", bus.req_ready_o);
    else n_pass++;
    ref_clear();
    er = ref_load('h20);
    cpu_op(1'b0, 'h20, '0, rd, lat, rc);
    n_checks++;
    if (rd !== mem_rd('h20) || rd_log.size() != er || er != WPL || bad_burst('h20) != 0)
      $display("FAIL midrefill_reload: got %h/%0d reads want %h/%0d", rd, rd_log.size(),
               mem_rd('h20), WPL);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] rd, exp, wd;
    int lat, er;
    int unsigned rc, a;
    bit we;
    for (int i = 0; i < 60; i++) begin
      ready_delay = $urandom_range(0, 2);
      rlat        = $urandom_range(1, 3);
      a           = $urandom_range(0, 127);
      we          = ($urandom_range(0, 2) == 0);
      wd          = {$urandom, $urandom};
      if (we) begin
        cpu_op(1'b1, a, wd, rd, lat, rc);
        n_checks++;
        if (rd !== '0) $display("FAIL rand_store_ack %0d: got %h want 0", i, rd);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] != a || wr_data[0] !== wd || rd_log.size() != 0)
          $display("FAIL rand_store_mem %0d: got %0d writes, %0d reads want 1 write at %h",
                   i, wr_addr.size(), rd_log.size(), a);
        else n_pass++;
      end else begin
        exp = mem_rd(a);
        er  = ref_load(a);
        cpu_op(1'b0, a, '0, rd, lat, rc);
        n_checks++;
        if (rd !== exp) $display("FAIL rand_load_data %0d: addr %h got %h want %h", i, a, rd, exp);
        else n_pass++;
        n_checks++;
        if (rd_log.size() != er || bad_burst(a) != 0 || wr_addr.size() != 0)
          $display("FAIL rand_load_reads %0d: addr %h got %0d reads want %0d", i, a,
                   rd_log.size(), er);
        else n_pass++;
      end
    end
    ready_delay = 0;
    rlat        = 1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_refill_hit();
    test_store_hit();
    test_store_miss();
    test_stall();
    test_flush();
    test_conflict();
    test_reset_mid_refill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache for the MEM stage of the pipelined core.
- Replaces the single-cycle flat data memory. Adds tags, multi-word lines, burst refill, flush, and valid/ready handshakes on both the CPU side and the memory side.
- The CPU side uses word addresses. The memory side transfers one word per beat.

Parameters:
- XLEN, 64, data word width in bits.
- ADDR_W, 32, word-address width in bits.
- LINES, 8, number of cache lines; must be a power of 2 and at least 2.
- WPL, 4, words per line; must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  CPU request valid.
- req_ready_o  out  1  cache can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  word address.
- req_wdata_i  in  XLEN  store data.
- resp_valid_o  out  1  one-cycle pulse: load data valid or store complete.
- resp_rdata_o  out  XLEN  load data; 0 for stores.
- flush_i  in  1  invalidate all lines.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory word address.
- mem_wdata_o  out  XLEN  memory write data.
- mem_rvalid_i  in  1  read beat returned.
- mem_rdata_i  in  XLEN  read beat data.

Behaviour:
- Reset (asynchronous, active-high; applies to reset asserted at any time, including mid-refill or mid-write):
  - State goes to IDLE and all valid bits clear.
  - All outputs are 0 except req_ready_o, which is 1 once reset deasserts.
  - Data and tag arrays are not reset.
- Address split: offset = addr[log2(WPL)-1:0]; index = next log2(LINES) bits; tag = remaining upper bits.
- State IDLE:
  - req_ready_o = !flush_i.
  - If flush_i is high: clear all valid bits this cycle; any request is not accepted. Flush has priority over a request.
  - Otherwise, req_valid_i && req_ready_o captures we/addr/wdata into request registers and moves to COMPARE.
- State COMPARE (req_ready_o = 0):
  - hit = valid[index] && tag match.
  - Load hit: resp_valid_o = 1 with the cached word, then IDLE. Load latency is one cycle after acceptance.
  - Load miss: clear valid[index], zero the beat counter, go to REFILL.
  - Store (hit or miss): go to WRITE. On a hit, the cached word is updated in this cycle.
- State REFILL:
  - Issue WPL sequential read requests with mem_addr_o = {tag, index, beat}, mem_we_o = 0, one outstanding at a time.
  - The request count advances when mem_req_valid_o && mem_req_ready_i. The next request is not issued until the previous beat's mem_rvalid_i.
  - Each mem_rvalid_i writes mem_rdata_i into word[beat] and increments the beat counter.
  - After the last beat: set tag and valid, then go to RESP.
  - mem_rvalid_i is ignored outside REFILL.
- State RESP:
  - resp_valid_o = 1 with resp_rdata_o = the requested word (from the array, or forwarded if it was the last beat), then IDLE.
  - Miss latency = one cycle after the final mem_rvalid_i.
- State WRITE:
  - mem_req_valid_o = 1, mem_we_o = 1, mem_addr_o and mem_wdata_o driven from the request registers.
  - Held stable until mem_req_ready_i.
  - On the handshake: resp_valid_o = 1, resp_rdata_o = 0, then IDLE.
  - No allocation on a store miss.
- Memory-side rule: mem_req_valid_o, once asserted, stays asserted with stable address and data until mem_req_ready_i.
- flush_i outside IDLE is ignored; the caller holds it until req_ready_o is seen.
- A conflicting index evicts the resident line with no writeback; this is correct because the cache is write-through.
- Every request produces exactly one resp_valid_o pulse.

Decomposition:
- Package dcache_pkg holds:
  - the state enum {IDLE, COMPARE, REFILL, RESP, WRITE};
  - index/offset/tag width localparam functions derived from ADDR_W, LINES and WPL.
- One sub-module, dcache_line_ram: LINES×WPL×XLEN data array with asynchronous read and synchronous single-word write.
- Tags and valid bits live in dcache_dm.

Test Plan (defaults; index = addr[4:2]):
- Reset, then load 0x10 with memory returning 0xA0..0xA3 for 0x10..0x13 -> exactly 4 read requests at 0x10..0x13; resp_rdata_o = 0xA0. Then load 0x12 -> resp_valid_o one cycle after acceptance, data 0xA2, no memory request.
- Store 0x11 data 0x55 after the line is resident -> one memory write at 0x11 with data 0x55, then an ack pulse. Then load 0x11 -> hit returning 0x55.
- Store 0x40 data 0x77 (miss) -> memory write only. Then load 0x40 -> miss with 4 reads at 0x40..0x43 (no allocation on the store).
- Load 0x10, then 0x30 (same index 4, different tag), then 0x10 again -> three refills; the third load misses.
- Hold mem_req_ready_i low for 5 cycles and delay mem_rvalid_i by 3 cycles -> mem_addr_o and mem_req_valid_o stay stable; the result is still correct, with a single resp pulse.
- Flush with a concurrent req_valid_i -> request not accepted that cycle; the next load to a previously resident line misses. Assert rst_i during beat 2 of a refill -> IDLE, all outputs 0, and the line is invalid (a reload misses).
